mac_seq_ctrl: RTL and testbench

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_seq_ctrl.sv | 102 ++++++++++
 tb/tb_mac_seq_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: runs one tile of weight fill, kernel load, activation fill, execute and OFIFO drain
module mac_seq_ctrl #(
  parameter int row = 8,
  parameter int col = 8,
  parameter int bw = 4,
  parameter int addr_w = 11,
  parameter int len_w = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [len_w-1:0]  len,
  input  logic [addr_w-1:0] w_base,
  input  logic [addr_w-1:0] x_base,
  input  logic              l0_full,
  input  logic              ofifo_valid,
  output logic              sram_rd_en,
  output logic [addr_w-1:0] sram_addr,
  output logic              l0_wr,
  output logic              l0_rd,
  output logic [1:0]        inst,
  output logic              ofifo_rd,
  output logic              busy,
  output logic              done
);
  localparam int cw = $clog2(row + 1) > len_w ? $clog2(row + 1) : len_w;
  typedef enum logic [2:0] {IDLE, WFILL, WLOAD, XFILL, XEXEC, DRAIN, DONE} state_t;
  state_t state;
  logic [cw-1:0] cnt, lim;
  logic [len_w-1:0] len_q;
  logic [addr_w-1:0] w_q, x_q;
  logic rd, last;
  if (row < 1 || col < 1 || bw < 1) begin : g_bad
    $error("mac_seq_ctrl: row, col and bw must be positive");
  end
  always_comb begin
    lim = state inside {WFILL, WLOAD} ? cw'(row) : cw'(len_q);
    rd = (state == WFILL || state == XFILL) && !l0_full && cnt < lim;
    last = rd && cnt == lim - 1'b1;
    sram_rd_en = rd;
    sram_addr = rd ? (state == WFILL ? w_q : x_q) + addr_w'(cnt) : '0;
    ofifo_rd = state == DRAIN && ofifo_valid;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      len_q <= '0;
      w_q <= '0;
      x_q <= '0;
      l0_wr <= 1'b0;
      l0_rd <= 1'b0;
      inst <= 2'b00;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      l0_wr <= rd;
      l0_rd <= 1'b0;
      inst <= 2'b00;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (len == '0) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            state <= WFILL;
            len_q <= len;
            w_q <= w_base;
            x_q <= x_base;
            cnt <= '0;
          end
        end
        WFILL, XFILL: if (rd) begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) state <= state == WFILL ? WLOAD : XEXEC;
        end
        WLOAD, XEXEC: if (cnt < lim) begin
          cnt <= cnt + 1'b1;
          l0_rd <= 1'b1;
          inst <= state == WLOAD ? 2'b01 : 2'b10;
        end else begin
          cnt <= '0;
          state <= state == WLOAD ? XFILL : DRAIN;
        end
        DRAIN: if (ofifo_valid) begin
          cnt <= cnt + 1'b1;
          if (cnt == lim - 1'b1) begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed and randomized tiles checked every cycle against a phase/count reference model
module tb_mac_seq_ctrl;
  localparam int row = 8;
  localparam int aw = 11;
  localparam int lw = 4;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, l0_full = 1'b0, ofifo_valid = 1'b0;
  logic [lw-1:0] len = '0;
  logic [aw-1:0] w_base = '0, x_base = '0;
  logic sram_rd_en, l0_wr, l0_rd, ofifo_rd, busy, done;
  logic [aw-1:0] sram_addr;
  logic [1:0] inst;
  int total = 0, bad = 0, cyc = 0, dones = 0;
  bit en = 1'b0, m_act = 1'b0, p_rd = 1'b0;
  int lm = 0, wb = 0, xb = 0, nw = 0, nx = 0, n01 = 0, n10 = 0, npop = 0, t_lw = 0, t_lx = 0;

  mac_seq_ctrl #(.row(row), .addr_w(aw), .len_w(lw)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .w_base(w_base), .x_base(x_base),
    .l0_full(l0_full), .ofifo_valid(ofifo_valid), .sram_rd_en(sram_rd_en), .sram_addr(sram_addr),
    .l0_wr(l0_wr), .l0_rd(l0_rd), .inst(inst), .ofifo_rd(ofifo_rd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit idle, phw, phx, phd, e_rd, in01, in10, e_done;
    int e_addr;
    cyc++;
    idle = !m_act;
    phw = m_act && lm != 0 && nw < row;
    phx = m_act && lm != 0 && n01 == row && nx < lm;
    e_rd = (phw || phx) && !l0_full;
    e_addr = (phw ? wb + nw : xb + nx) % (1 << aw);
    in01 = m_act && lm != 0 && nw == row && cyc >= t_lw + 2 && n01 < row;
    in10 = m_act && lm != 0 && nx == lm && cyc >= t_lx + 2 && n10 < lm;
    phd = m_act && lm != 0 && n10 == lm && npop < lm;
    e_done = m_act && npop == lm;
    if (en) begin
      chk("busy", int'(busy), int'(m_act));
      chk("done", int'(done), int'(e_done));
      chk("sram_rd_en", int'(sram_rd_en), int'(e_rd));
      if (e_rd) chk("sram_addr", int'(sram_addr), e_addr);
      chk("l0_wr", int'(l0_wr), int'(p_rd));
      chk("l0_rd", int'(l0_rd), int'(in01 || in10));
      chk("inst", int'(inst), int'({in10, in01}));
      chk("ofifo_rd", int'(ofifo_rd), int'(phd && ofifo_valid));
      if (done) dones++;
    end
    if (e_rd) begin
      if (phw) begin
        nw++;
        if (nw == row) t_lw = cyc;
      end else begin
        nx++;
        if (nx == lm) t_lx = cyc;
      end
    end
    if (in01) n01++;
    if (in10) n10++;
    if (phd && ofifo_valid) npop++;
    if (e_done) m_act = 1'b0;
    p_rd = e_rd;
    if (idle && start && !reset) begin
      m_act = 1'b1;
      lm = int'(len);
      wb = int'(w_base);
      xb = int'(x_base);
      nw = 0; nx = 0; n01 = 0; n10 = 0; npop = 0; t_lw = 0; t_lx = 0;
    end
    if (reset) begin
      m_act = 1'b0;
      p_rd = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int l, input int w, input int x, input int mode);
    int k, pi, d0;
    bit pat[6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    k = 0;
    pi = 0;
    d0 = dones;
    start = 1'b1;
    len = lw'(l);
    w_base = aw'(w);
    x_base = aw'(x);
    l0_full = 1'b0;
    ofifo_valid = 1'b1;
    tick();
    start = 1'b0;
    while (dones == d0 && k < 400) begin
      k++;
      l0_full = mode == 1 ? $urandom_range(0, 3) == 0 : mode == 2 ? (k >= 3 && k <= 5) : 1'b0;
      if (mode == 3 && n10 == lm && npop < lm) begin
        ofifo_valid = pi < 6 ? pat[pi] : 1'b1;
        pi++;
      end else ofifo_valid = mode == 1 ? $urandom_range(0, 9) < 7 : mode != 3;
      if (mode == 1) begin
        start = $urandom_range(0, 7) == 0;
        len = lw'($urandom);
      end
      tick();
    end
    start = 1'b0;
    chk("tile_done", dones - d0, 1);
  endtask

  initial begin
    int d0;
    repeat (2) @(posedge clk);
    #1;
    en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    run(4, 'h010, 'h100, 0);
    run(4, 'h020, 'h200, 2);
    run(4, 'h030, 'h300, 3);
    run(0, 'h040, 'h400, 0);
    run(3, 'h7FE, 'h7FD, 0);
    d0 = dones;
    start = 1'b1;
    len = 4'd4;
    w_base = aw'('h050);
    x_base = aw'('h500);
    ofifo_valid = 1'b1;
    tick();
    len = 4'd0;
    for (int k = 0; k < 100 && n10 == 0; k++) tick();
    chk("reached_xexec", int'(n10 > 0), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    repeat (20) tick();
    chk("no_done_after_reset", dones - d0, 0);
    run(5, 'h060, 'h600, 0);
    repeat (40) run($urandom_range(0, 15), $urandom, $urandom, 1);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
